// File: rtl/stc0_egress_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// stc0_egress_serializer : buffers NUM_LANES-sample beats and streams them
// MSB-first onto the 8-bit ED bus with backpressure and optional headers.
// Rev 1.0
// ============================================================================
module stc0_egress_serializer #(
  parameter int         DATA_WIDTH      = 16,
  parameter int         NUM_LANES       = 2,
  parameter int         FIFO_DEPTH_LOG2 = 4,
  parameter int         READY_MARGIN    = 2,
  parameter int         FRAME_BEATS     = 8,
  parameter logic [7:0] SYNC_BYTE       = 8'hA5
) (
  input  logic                              Clk,
  input  logic                              Rst,
  input  logic [NUM_LANES*2*DATA_WIDTH-1:0] IngressData,
  input  logic                              IngressValid,
  output logic                              IngressReady,
  input  logic                              HeaderEn,
  output logic [7:0]                        ED,
  output logic                              EValid,
  input  logic                              ERdy,
  output logic                              Overflow,
  output logic [FIFO_DEPTH_LOG2:0]          FifoCount
);

  localparam int c_W      = NUM_LANES * 2 * DATA_WIDTH;
  localparam int c_BYTES  = c_W / 8;
  localparam int c_DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam int c_CW     = FIFO_DEPTH_LOG2 + 1;
  localparam int c_IDX_W  = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
  localparam int c_BEAT_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;

  localparam logic [1:0] c_S_IDLE     = 2'd0;
  localparam logic [1:0] c_S_HDR_SYNC = 2'd1;
  localparam logic [1:0] c_S_HDR_SEQ  = 2'd2;
  localparam logic [1:0] c_S_DATA     = 2'd3;

  logic [c_W-1:0]             mem_q [c_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [c_CW-1:0]            count_q, count_d;
  logic [1:0]                 state_q, state_d;
  logic [c_IDX_W-1:0]         idx_q, idx_d;
  logic [c_BEAT_W-1:0]        beat_q, beat_d;
  logic [7:0]                 seq_q, seq_d;
  logic [7:0]                 ed_q, ed_d;
  logic                       evalid_q, evalid_d;
  logic                       ovf_q;

  logic                       w_empty, w_full, w_xfer, w_last, w_pop, w_push, w_drop;
  logic                       w_remain, w_beat_wrap, w_hdr_now, w_hdr_next;
  logic [FIFO_DEPTH_LOG2-1:0] w_rd_next;
  logic [c_W-1:0]             w_head, w_next_head;

  function automatic logic [7:0] f_byte(input logic [c_W-1:0] word, input logic [c_IDX_W-1:0] k);
    logic [c_W-1:0] sh;
    sh = word << {k, 3'b000};
    return sh[c_W-1 -: 8];
  endfunction

  assign w_empty     = (count_q == '0);
  assign w_full      = (count_q == c_CW'(c_DEPTH));
  assign w_xfer      = evalid_q && ERdy;
  assign w_last      = (state_q == c_S_DATA) && (idx_q == c_IDX_W'(c_BYTES - 1));
  assign w_pop       = w_xfer && w_last;
  assign w_push      = IngressValid && (!w_full || w_pop);
  assign w_drop      = IngressValid && w_full && !w_pop;
  assign w_rd_next   = rd_ptr_q + 1'b1;
  assign w_head      = mem_q[rd_ptr_q];
  // A beat pushed on the same edge the sole entry pops is forwarded so the stream has no bubble.
  assign w_next_head = (count_q > c_CW'(1)) ? mem_q[w_rd_next] : IngressData;
  assign w_remain    = (count_q > c_CW'(1)) || w_push;
  assign w_beat_wrap = (beat_q == c_BEAT_W'(FRAME_BEATS - 1));
  assign w_hdr_now   = HeaderEn && (beat_q == '0);
  assign w_hdr_next  = HeaderEn && w_beat_wrap;

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (w_push) mem_q[wr_ptr_q] <= IngressData;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= c_S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      beat_q   <= '0;
      seq_q    <= '0;
      ed_q     <= '0;
      evalid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      beat_q   <= beat_d;
      seq_q    <= seq_d;
      ed_q     <= ed_d;
      evalid_q <= evalid_d;
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= w_rd_next;
      if (w_drop) ovf_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_S_IDLE:     if (!w_empty) state_d = w_hdr_now ? c_S_HDR_SYNC : c_S_DATA;
      c_S_HDR_SYNC: if (w_xfer) state_d = c_S_HDR_SEQ;
      c_S_HDR_SEQ:  if (w_xfer) state_d = c_S_DATA;
      c_S_DATA: begin
        if (w_pop) begin
          if (w_remain) state_d = w_hdr_next ? c_S_HDR_SYNC : c_S_DATA;
          else          state_d = c_S_IDLE;
        end
      end
      default:      state_d = c_S_IDLE;
    endcase
  end

  always_comb begin
    ed_d     = ed_q;
    evalid_d = evalid_q;
    idx_d    = idx_q;
    beat_d   = beat_q;
    seq_d    = seq_q;
    if (w_pop) begin
      beat_d = w_beat_wrap ? '0 : beat_q + 1'b1;
      if (w_beat_wrap) seq_d = seq_q + 8'd1;
    end
    case (state_q)
      c_S_IDLE: begin
        if (!w_empty) begin
          evalid_d = 1'b1;
          idx_d    = '0;
          ed_d     = w_hdr_now ? SYNC_BYTE : f_byte(w_head, '0);
        end
      end
      c_S_HDR_SYNC: if (w_xfer) ed_d = seq_q;
      c_S_HDR_SEQ: begin
        if (w_xfer) begin
          ed_d  = f_byte(w_head, '0);
          idx_d = '0;
        end
      end
      c_S_DATA: begin
        if (w_xfer) begin
          if (w_last) begin
            idx_d = '0;
            if (w_remain) ed_d = w_hdr_next ? SYNC_BYTE : f_byte(w_next_head, '0);
            else          evalid_d = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
            ed_d  = f_byte(w_head, idx_q + 1'b1);
          end
        end
      end
      default: begin
        evalid_d = 1'b0;
        idx_d    = '0;
      end
    endcase
  end

  assign ED           = ed_q;
  assign EValid       = evalid_q;
  assign Overflow     = ovf_q;
  assign FifoCount    = count_q;
  assign IngressReady = (count_q <= c_CW'(c_DEPTH - 1 - READY_MARGIN));

endmodule
`default_nettype wire

// File: tb/tb_stc0_egress_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_stc0_egress_serializer : scoreboard bench for the egress serializer.
// Rev 1.0
// ============================================================================
module tb_stc0_egress_serializer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] a_data, b_data;
  logic        a_valid, b_valid, a_hdr, b_hdr, a_rdy, b_rdy;
  logic        a_ready, b_ready, a_ev, b_ev, a_ovf, b_ovf;
  logic [7:0]  a_ed, b_ed;
  logic [4:0]  a_cnt, b_cnt;

  stc0_egress_serializer dut_a (
    .Clk(clk), .Rst(rst), .IngressData(a_data), .IngressValid(a_valid),
    .IngressReady(a_ready), .HeaderEn(a_hdr), .ED(a_ed), .EValid(a_ev),
    .ERdy(a_rdy), .Overflow(a_ovf), .FifoCount(a_cnt)
  );

  stc0_egress_serializer #(.DATA_WIDTH(8), .NUM_LANES(4)) dut_b (
    .Clk(clk), .Rst(rst), .IngressData(b_data), .IngressValid(b_valid),
    .IngressReady(b_ready), .HeaderEn(b_hdr), .ED(b_ed), .EValid(b_ev),
    .ERdy(b_rdy), .Overflow(b_ovf), .FifoCount(b_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int         m_beat;
  logic [7:0] m_seq;

  // Expected byte stream for instance A: optional header at frame start, then MSB-first data.
  task automatic sb_push_a(input logic [63:0] d);
    if (m_beat == 0 && a_hdr) begin
      qa.push_back(8'hA5);
      qa.push_back(m_seq);
    end
    for (int k = 0; k < 8; k++) qa.push_back(d[63-8*k -: 8]);
    m_beat++;
    if (m_beat == 8) begin
      m_beat = 0;
      m_seq  = m_seq + 8'd1;
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic       a_hold;
  logic [7:0] a_hold_ed;
  int         a_xfer_cnt, a_first_cyc, a_last_cyc;

  always @(negedge clk) begin
    if (rst) begin
      a_hold     = 1'b0;
      a_xfer_cnt = 0;
    end else begin
      if (a_hold) begin
        chk("a_hold_valid", 64'(a_ev), 64'(1'b1));
        chk("a_hold_data", 64'(a_ed), 64'(a_hold_ed));
      end
      if (a_ev && a_rdy) begin
        if (qa.size() == 0) chk("a_extra_byte", 64'(a_ed), 64'hFFFF);
        else chk("a_byte", 64'(a_ed), 64'(qa.pop_front()));
        if (a_xfer_cnt == 0) a_first_cyc = cyc;
        a_last_cyc = cyc;
        a_xfer_cnt++;
      end
      a_hold    = a_ev && !a_rdy;
      a_hold_ed = a_ed;
    end
  end

  always @(negedge clk) begin
    if (!rst && b_ev && b_rdy) begin
      if (qb.size() == 0) chk("b_extra_byte", 64'(b_ed), 64'hFFFF);
      else chk("b_byte", 64'(b_ed), 64'(qb.pop_front()));
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    qa.delete();
    qb.delete();
    m_beat = 0;
    m_seq  = 8'd0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic push_a(input logic [63:0] d, input bit acc);
    @(posedge clk); #1;
    a_data  = d;
    a_valid = 1'b1;
    if (acc) sb_push_a(d);
  endtask

  task automatic idle_a();
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic push_b(input logic [63:0] d);
    @(posedge clk); #1;
    b_data  = d;
    b_valid = 1'b1;
  endtask

  task automatic wait_drain(input string tag, input int limit);
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || a_ev || b_ev) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(n < limit), 64'(1'b1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] d;
    logic [3:0]  pat;
    int          n, guard;

    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
    a_hdr = 1'b0; b_hdr = 1'b1; a_rdy = 1'b1; b_rdy = 1'b1;
    m_beat = 0; m_seq = 8'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_ed", 64'(a_ed), 64'h0);
    chk("rst_evalid", 64'(a_ev), 64'h0);
    chk("rst_overflow", 64'(a_ovf), 64'h0);
    chk("rst_count", 64'(a_cnt), 64'h0);
    chk("rst_ready", 64'(a_ready), 64'h1);
    chk("rst_b_evalid", 64'(b_ev), 64'h0);

    // Single beat, no header: latency and byte order
    push_a(64'h1111_2222_3333_4444, 1'b1);
    idle_a();
    chk("t1_evalid_early", 64'(a_ev), 64'h0);
    chk("t1_count_one", 64'(a_cnt), 64'h1);
    @(posedge clk); #1;
    chk("t1_evalid_rise", 64'(a_ev), 64'h1);
    chk("t1_first_byte", 64'(a_ed), 64'h11);
    wait_drain("t1_drain", 100);
    chk("t1_count_zero", 64'(a_cnt), 64'h0);

    // Four-lane, 8-bit instance with a header on its first frame
    qb.push_back(8'hA5);
    qb.push_back(8'h00);
    for (int i = 0; i < 2; i++) begin
      d = {$urandom, $urandom};
      for (int k = 0; k < 8; k++) qb.push_back(d[63-8*k -: 8]);
      push_b(d);
    end
    @(posedge clk); #1 b_valid = 1'b0;
    wait_drain("b_drain", 100);

    // Nine beats back to back with headers: must stream without gaps
    do_reset();
    a_hdr = 1'b1;
    for (int i = 0; i < 9; i++) push_a({$urandom, $urandom}, 1'b1);
    idle_a();
    wait_drain("t2_drain", 300);
    chk("t2_bytes", 64'(a_xfer_cnt), 64'd76);
    chk("t2_span", 64'(a_last_cyc - a_first_cyc + 1), 64'd76);

    // Backpressure pattern 1,0,0,1
    do_reset();
    a_hdr = 1'b0;
    pat   = 4'b1001;
    for (int i = 0; i < 3; i++) push_a({$urandom, $urandom}, 1'b1);
    idle_a();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      a_rdy = pat[3 - (i % 4)];
    end
    @(posedge clk); #1 a_rdy = 1'b1;
    wait_drain("t3_drain", 300);

    // Overflow: 17 pushes into a stalled FIFO, 16 kept
    do_reset();
    a_rdy = 1'b0;
    for (int k = 0; k < 17; k++) begin
      push_a({$urandom, $urandom}, k < 16);
      if (k >= 1) begin
        chk("t4_count", 64'(a_cnt), 64'(k));
        chk("t4_ready", 64'(a_ready), 64'(k <= 13));
      end
    end
    idle_a();
    chk("t4_count_full", 64'(a_cnt), 64'd16);
    chk("t4_overflow", 64'(a_ovf), 64'h1);
    a_rdy = 1'b1;
    wait_drain("t4_drain", 400);
    chk("t4_overflow_sticky", 64'(a_ovf), 64'h1);
    chk("t4_count_empty", 64'(a_cnt), 64'h0);

    // Push accepted while full on the same edge as a pop
    do_reset();
    a_rdy = 1'b0;
    for (int k = 0; k < 16; k++) push_a({$urandom, $urandom}, 1'b1);
    idle_a();
    a_rdy = 1'b1;
    repeat (6) @(posedge clk);
    push_a({$urandom, $urandom}, 1'b1);
    chk("t5_count_before_pop", 64'(a_cnt), 64'd16);
    idle_a();
    chk("t5_count_at_pop", 64'(a_cnt), 64'd16);
    chk("t5_no_overflow", 64'(a_ovf), 64'h0);
    wait_drain("t5_drain", 400);

    // 256 frames of headers so the sequence byte wraps to 00
    do_reset();
    a_hdr = 1'b1;
    n = 0;
    guard = 0;
    while (n < 2049 && guard < 40000) begin
      @(posedge clk); #1;
      guard++;
      if (a_ready) begin
        d = {$urandom, $urandom};
        a_data  = d;
        a_valid = 1'b1;
        sb_push_a(d);
        n++;
      end else begin
        a_valid = 1'b0;
      end
    end
    idle_a();
    chk("t5_push_bound", 64'(n), 64'd2049);
    wait_drain("t5_wrap_drain", 3000);

    // Reset while the third byte is on the bus
    do_reset();
    a_hdr = 1'b1;
    d = 64'hCAFE_BABE_0123_4567;
    push_a(d, 1'b1);
    idle_a();
    repeat (3) @(posedge clk);
    #1;
    chk("t6_third_byte", 64'(a_ed), 64'hCA);
    rst = 1'b1;
    qa.delete();
    m_beat = 0;
    m_seq  = 8'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_evalid_cleared", 64'(a_ev), 64'h0);
    chk("t6_count_cleared", 64'(a_cnt), 64'h0);
    repeat (5) @(posedge clk);
    #1;
    chk("t6_stays_idle", 64'(a_ev), 64'h0);
    push_a(64'h0102_0304_0506_0708, 1'b1);
    idle_a();
    @(posedge clk); #1;
    chk("t6_header_sync", 64'(a_ed), 64'hA5);
    wait_drain("t6_drain", 100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
